// File: rtl/countdown_mmss_if.sv
// Control and data bundle between the button front end, the countdown core and the display driver.
interface countdown_mmss_if;
    logic       decrease;
    logic       start_stop;
    logic       load;
    logic [3:0] set_min1;
    logic [3:0] set_min0;
    logic [3:0] set_sec1;
    logic [3:0] set_sec0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
    logic       running;
    logic       expired;
    logic       done;

    modport master (
        output decrease, start_stop, load,
        output set_min1, set_min0, set_sec1, set_sec0,
        input  min1, min0, sec1, sec0, running, expired, done
    );

    modport slave (
        input  decrease, start_stop, load,
        input  set_min1, set_min0, set_sec1, set_sec0,
        output min1, min0, sec1, sec0, running, expired, done
    );
endinterface

// File: rtl/countdown_mmss.sv
// Four-digit BCD MM:SS countdown with load clamping, run/pause control and expiry pulse.
//
// state | meaning
// IDLE  | stopped, digits loadable, start needs nonzero digits
// RUN   | counting down on each decrease tick
// PAUSE | stopped mid-count, digits hold
// DONE  | reached 00:00, expired high until start_stop or load
module countdown_mmss (
    input logic             clk_out,
    input logic             rst_n,
    countdown_mmss_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t     state_q, state_d;
    logic [3:0] m1_q, m0_q, s1_q, s0_q;
    logic [3:0] m1_d, m0_d, s1_d, s0_d;
    logic [3:0] m1_dec, m0_dec, s1_dec, s0_dec;
    logic [3:0] m1_ld, m0_ld, s1_ld, s0_ld;
    logic       done_q, done_d;
    logic       is_zero, dec_zero;
    logic       do_load, do_dec;

    // Borrow ripples upward only while the lower digit is wrapping.
    always_comb begin
        s0_dec = s0_q - 4'd1;
        s1_dec = s1_q;
        m0_dec = m0_q;
        m1_dec = m1_q;
        if (s0_q == 4'd0) begin
            s0_dec = 4'd9;
            s1_dec = s1_q - 4'd1;
            if (s1_q == 4'd0) begin
                s1_dec = 4'd5;
                m0_dec = m0_q - 4'd1;
                if (m0_q == 4'd0) begin
                    m0_dec = 4'd9;
                    m1_dec = m1_q - 4'd1;
                end
            end
        end
    end

    assign m1_ld = (bus.set_min1 > 4'd9) ? 4'd9 : bus.set_min1;
    assign m0_ld = (bus.set_min0 > 4'd9) ? 4'd9 : bus.set_min0;
    assign s1_ld = (bus.set_sec1 > 4'd5) ? 4'd5 : bus.set_sec1;
    assign s0_ld = (bus.set_sec0 > 4'd9) ? 4'd9 : bus.set_sec0;

    assign is_zero  = ({m1_q, m0_q, s1_q, s0_q} == 16'h0000);
    assign dec_zero = ({m1_dec, m0_dec, s1_dec, s0_dec} == 16'h0000);

    always_comb begin
        state_d = state_q;
        do_load = 1'b0;
        do_dec  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.load)                       do_load = 1'b1;
                else if (bus.start_stop && !is_zero) state_d = RUN;
            end
            RUN: begin
                if (bus.decrease) begin
                    do_dec = 1'b1;
                    if (dec_zero) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else if (bus.start_stop) begin
                        state_d = PAUSE;
                    end
                end else if (bus.start_stop) begin
                    state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (bus.load) begin
                    do_load = 1'b1;
                    state_d = IDLE;
                end else if (bus.start_stop) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                if (bus.load) begin
                    do_load = 1'b1;
                    state_d = IDLE;
                end else if (bus.start_stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        {m1_d, m0_d, s1_d, s0_d} = {m1_q, m0_q, s1_q, s0_q};
        if (do_load)     {m1_d, m0_d, s1_d, s0_d} = {m1_ld, m0_ld, s1_ld, s0_ld};
        else if (do_dec) {m1_d, m0_d, s1_d, s0_d} = {m1_dec, m0_dec, s1_dec, s0_dec};
    end

    always_ff @(posedge clk_out or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            m1_q    <= 4'd0;
            m0_q    <= 4'd0;
            s1_q    <= 4'd0;
            s0_q    <= 4'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m1_q    <= m1_d;
            m0_q    <= m0_d;
            s1_q    <= s1_d;
            s0_q    <= s0_d;
            done_q  <= done_d;
        end
    end

    assign bus.min1    = m1_q;
    assign bus.min0    = m0_q;
    assign bus.sec1    = s1_q;
    assign bus.sec0    = s0_q;
    assign bus.running = (state_q == RUN);
    assign bus.expired = (state_q == DONE);
    assign bus.done    = done_q;
endmodule

// File: tb/tb_countdown_mmss.sv
// Directed vector bench for the MM:SS countdown timer.
module tb_countdown_mmss;
    logic clk_out = 1'b0;
    logic rst_n   = 1'b0;
    int   errors  = 0;
    int   checks  = 0;

    countdown_mmss_if bus ();

    countdown_mmss dut (
        .clk_out (clk_out),
        .rst_n   (rst_n),
        .bus     (bus)
    );

    always #5 clk_out = ~clk_out;

    typedef struct {
        logic        ld;
        logic        ss;
        logic        dc;
        logic [15:0] set;
        logic [15:0] exp_digits;
        logic        exp_run;
        logic        exp_exp;
        logic        exp_done;
    } vec_t;

    vec_t vecs[$];

    function automatic void v(input logic ld, input logic ss, input logic dc,
                              input logic [15:0] set, input logic [15:0] ed,
                              input logic er, input logic ee, input logic edn);
        vec_t t;
        t.ld = ld; t.ss = ss; t.dc = dc; t.set = set;
        t.exp_digits = ed; t.exp_run = er; t.exp_exp = ee; t.exp_done = edn;
        vecs.push_back(t);
    endfunction

    task automatic chk(input string nm, input int idx, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, idx, got, exp);
        end
    endtask

    task automatic check_all(input int idx, input logic [15:0] ed, input logic er,
                             input logic ee, input logic edn);
        chk("digits",  idx, {bus.min1, bus.min0, bus.sec1, bus.sec0}, ed);
        chk("running", idx, {15'd0, bus.running}, {15'd0, er});
        chk("expired", idx, {15'd0, bus.expired}, {15'd0, ee});
        chk("done",    idx, {15'd0, bus.done},    {15'd0, edn});
    endtask

    task automatic step(input logic ld, input logic ss, input logic dc, input logic [15:0] set);
        bus.load       = ld;
        bus.start_stop = ss;
        bus.decrease   = dc;
        {bus.set_min1, bus.set_min0, bus.set_sec1, bus.set_sec0} = set;
        @(posedge clk_out);
        #1;
        bus.load       = 1'b0;
        bus.start_stop = 1'b0;
        bus.decrease   = 1'b0;
    endtask

    initial begin
        bus.load = 1'b0; bus.start_stop = 1'b0; bus.decrease = 1'b0;
        {bus.set_min1, bus.set_min0, bus.set_sec1, bus.set_sec0} = 16'h0000;

        //   ld ss dc  set       digits   run exp done
        v(1, 0, 0, 16'h1000, 16'h1000, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h1000, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0959, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0958, 1, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0958, 0, 0, 0);
        v(1, 0, 0, 16'h0100, 16'h0100, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0100, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0059, 1, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0059, 0, 0, 0);
        v(1, 0, 0, 16'h0002, 16'h0002, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0002, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0001, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 1);
        v(0, 0, 0, 16'h0000, 16'h0000, 0, 1, 0);
        v(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        v(0, 0, 1, 16'h0000, 16'h0000, 0, 1, 0);
        v(1, 0, 0, 16'h0530, 16'h0530, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0530, 1, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0530, 0, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0530, 0, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0530, 0, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0530, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0530, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0529, 1, 0, 0);
        v(1, 0, 0, 16'h1111, 16'h0529, 1, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0529, 0, 0, 0);
        v(1, 0, 0, 16'h997C, 16'h9959, 0, 0, 0);
        v(1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0000, 0, 0, 0);
        v(1, 0, 0, 16'h0001, 16'h0001, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0001, 1, 0, 0);
        v(0, 1, 1, 16'h0000, 16'h0000, 0, 1, 1);
        v(0, 1, 0, 16'h0000, 16'h0000, 0, 0, 0);
        v(1, 0, 0, 16'h0300, 16'h0300, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0300, 1, 0, 0);
        v(0, 1, 1, 16'h0000, 16'h0259, 0, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h0259, 0, 0, 0);
        v(1, 1, 0, 16'h0707, 16'h0707, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0707, 1, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h0707, 0, 0, 0);
        v(1, 0, 0, 16'hCF99, 16'h9959, 0, 0, 0);
        v(0, 1, 0, 16'h0000, 16'h9959, 1, 0, 0);
        v(0, 0, 1, 16'h0000, 16'h9958, 1, 0, 0);

        #12;
        check_all(-1, 16'h0000, 1'b0, 1'b0, 1'b0);
        @(negedge clk_out);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].ld, vecs[i].ss, vecs[i].dc, vecs[i].set);
            check_all(i, vecs[i].exp_digits, vecs[i].exp_run, vecs[i].exp_exp, vecs[i].exp_done);
        end

        // Asynchronous reset in the middle of a run, observed before any further edge.
        step(0, 1, 0, 16'h0000);
        step(1, 0, 0, 16'h1234);
        step(0, 1, 0, 16'h0000);
        check_all(100, 16'h1234, 1'b1, 1'b0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_all(101, 16'h0000, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
